// File: rtl/finn_stream_pkg.sv
// Shared constants and helpers for the FINN-style stream adapters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default element width, monitor counter width, index sizing helper,
//           packing-order constant (LSB-first: element 0 lands in bits [IN_W-1:0]).
package finn_stream_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int CNT_W_DEF = 9;

  // 1 = first accepted element of a word occupies the least significant slot.
  localparam bit PACK_LSB_FIRST = 1'b1;

  // Width needed to hold an index 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/axis_upsizer_reader_if.sv
// AXI-Stream style bundle (data/valid/ready) used for both the narrow input and wide output.
// Latency: n/a (wires only).
// Backpressure: TREADY flows from slave to master.
// Ports: TDATA [W-1:0], TVALID, TREADY; master drives data/valid, slave drives ready.
interface axis_upsizer_reader_if #(
  parameter int W = 8
) ();

  logic [W-1:0] TDATA;
  logic         TVALID;
  logic         TREADY;

  modport master (output TDATA, output TVALID, input TREADY);
  modport slave  (input TDATA, input TVALID, output TREADY);

endinterface

// File: rtl/axis_out_reg.sv
// Output word register with valid flag for the upsizer.
// Latency: a load presents TVALID/TDATA on the following cycle.
// Backpressure: word and valid are frozen while TVALID=1 and TREADY=0.
// Ports: ap_clk, ap_rst_n (sync, active-low), load_i/load_dat_i (new word),
//        out_V (master side of the wide stream).
module axis_out_reg #(
  parameter int W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  load_i,
  input  logic [W-1:0]          load_dat_i,
  axis_upsizer_reader_if.master out_V
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  // The parent only raises load_i when the register is empty or being drained
  // this cycle, so a load always wins and keeps valid high without a bubble.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = load_dat_i;
    end else if (vld_q && out_V.TREADY) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_V.TVALID = vld_q;
  assign out_V.TDATA  = dat_q;

endmodule

// File: rtl/axis_upsizer_reader.sv
// Packs RATIO consecutive IN_W-bit stream elements into one wide word, with frame monitors.
// Latency: 1 cycle from the last element of a word to TVALID on the output.
// Backpressure: input stalls only when the final element would overwrite an unconsumed word.
// Ports: ap_clk, ap_rst_n (sync, active-low), in0_V (narrow slave stream),
//        out_V (wide master stream), beat_count, word_count, frame_done.
module axis_upsizer_reader
  import finn_stream_pkg::*;
#(
  parameter int IN_W      = IN_W_DEF,
  parameter int RATIO     = 4,
  parameter int NUM_WORDS = 256,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  axis_upsizer_reader_if.slave  in0_V,
  axis_upsizer_reader_if.master out_V,
  output logic [CNT_W-1:0]      beat_count,
  output logic [CNT_W-1:0]      word_count,
  output logic                  frame_done
);

  localparam int                IDX_W     = clog2_min1(RATIO);
  localparam int                ACC_W     = (RATIO - 1) * IN_W;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(NUM_WORDS - 1);

  if (RATIO < 2) begin : g_ratio_check
    $error("axis_upsizer_reader: RATIO must be at least 2");
  end

  // Slot index of element k inside the packed output word.
  function automatic int slot_pos(input int k);
    return PACK_LSB_FIRST ? k : (RATIO - 1 - k);
  endfunction

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic [CNT_W-1:0]       word_q, word_d;
  logic                   frame_done_q, frame_done_d;
  logic                   in_rdy, in_xfer, last_xfer, out_xfer, frame_wrap;
  logic [IN_W*RATIO-1:0]  load_dat;

  // Only the final element of a word needs room in the output register;
  // out_V.TREADY reaching here is the sole combinational ready path.
  assign in_rdy       = ap_rst_n && ((idx_q != IDX_LAST) || !out_V.TVALID || out_V.TREADY);
  assign in0_V.TREADY = in_rdy;
  assign in_xfer      = in0_V.TVALID && in_rdy;
  assign last_xfer    = in_xfer && (idx_q == IDX_LAST);
  assign out_xfer     = out_V.TVALID && out_V.TREADY;
  assign frame_wrap   = out_xfer && (word_q == WORD_LAST);

  always_comb begin
    load_dat = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      load_dat[slot_pos(k)*IN_W +: IN_W] = acc_q[k*IN_W +: IN_W];
    end
    load_dat[slot_pos(RATIO-1)*IN_W +: IN_W] = in0_V.TDATA;
  end

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (in_xfer) begin
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        acc_d[int'(idx_q)*IN_W +: IN_W] = in0_V.TDATA;
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // A beat accepted on the same edge as the frame wrap belongs to the new
  // frame, so the cleared counter restarts at one rather than zero.
  always_comb begin
    beat_d       = beat_q;
    word_d       = word_q;
    frame_done_d = 1'b0;
    if (in_xfer && (beat_q != '1)) begin
      beat_d = beat_q + CNT_W'(1);
    end
    if (out_xfer) begin
      word_d = frame_wrap ? '0 : word_q + CNT_W'(1);
    end
    if (frame_wrap) begin
      frame_done_d = 1'b1;
      beat_d       = in_xfer ? CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      idx_q        <= '0;
      acc_q        <= '0;
      beat_q       <= '0;
      word_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      beat_q       <= beat_d;
      word_q       <= word_d;
      frame_done_q <= frame_done_d;
    end
  end

  axis_out_reg #(
    .W (IN_W * RATIO)
  ) u_out_reg (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .load_i     (last_xfer),
    .load_dat_i (load_dat),
    .out_V      (out_V)
  );

  assign beat_count = beat_q;
  assign word_count = word_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_axis_upsizer_reader.sv
// Directed and randomized checks of axis_upsizer_reader (RATIO=4).
// Instance a: NUM_WORDS=256; instance b: NUM_WORDS=3 for frame wrap behaviour.
// Inputs change 1ns after the rising edge; outputs are checked 1-2ns after it.
module tb_axis_upsizer_reader;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  axis_upsizer_reader_if #(.W(8))  a_in ();
  axis_upsizer_reader_if #(.W(32)) a_out ();
  axis_upsizer_reader_if #(.W(8))  b_in ();
  axis_upsizer_reader_if #(.W(32)) b_out ();

  logic [8:0] a_beat, a_word, b_beat, b_word;
  logic       a_fd, b_fd;

  axis_upsizer_reader #(.IN_W(8), .RATIO(4), .NUM_WORDS(256), .CNT_W(9)) dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in0_V(a_in), .out_V(a_out),
    .beat_count(a_beat), .word_count(a_word), .frame_done(a_fd));

  axis_upsizer_reader #(.IN_W(8), .RATIO(4), .NUM_WORDS(3), .CNT_W(9)) dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in0_V(b_in), .out_V(b_out),
    .beat_count(b_beat), .word_count(b_word), .frame_done(b_fd));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n     = 1'b0;
    a_in.TVALID  = 1'b0;
    a_out.TREADY = 1'b0;
    tick();
    tick();
    ap_rst_n = 1'b1;
  endtask

  // Scoreboard state for the random phase.
  logic [31:0] exp_q[$];
  logic [31:0] part;
  int          part_n;
  int          accepted;
  int          words_out;
  int          fd_pulses;
  logic        prev_stall;
  logic [31:0] prev_dat;

  task automatic rand_cycle(input bit drain);
    logic in_acc, out_acc;
    tick();
    if (a_fd) fd_pulses++;
    if (drain) begin
      a_in.TVALID  = 1'b0;
      a_out.TREADY = 1'b1;
    end else begin
      a_in.TVALID  = ($urandom_range(0, 3) != 0);
      a_in.TDATA   = 8'($urandom);
      a_out.TREADY = ($urandom_range(0, 4) < 3);
    end
    if (accepted >= 10000) a_in.TVALID = 1'b0;
    settle();
    if (prev_stall) begin
      chk("rand_hold_vld", a_out.TVALID, 1'b1);
      chk("rand_hold_dat", a_out.TDATA, prev_dat);
    end
    in_acc  = a_in.TVALID && a_in.TREADY;
    out_acc = a_out.TVALID && a_out.TREADY;
    if (out_acc) begin
      chk("rand_word_avail", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) chk("rand_word", a_out.TDATA, exp_q.pop_front());
      words_out++;
    end
    if (in_acc) begin
      part = part | (32'(a_in.TDATA) << (8 * part_n));
      part_n++;
      accepted++;
      if (part_n == 4) begin
        exp_q.push_back(part);
        part   = '0;
        part_n = 0;
      end
    end
    prev_stall = a_out.TVALID && !a_out.TREADY;
    prev_dat   = a_out.TDATA;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errs);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int nw;
    ap_rst_n     = 1'b0;
    a_in.TVALID  = 1'b0;
    a_in.TDATA   = '0;
    a_out.TREADY = 1'b0;
    b_in.TVALID  = 1'b0;
    b_in.TDATA   = '0;
    b_out.TREADY = 1'b1;

    // ---------------- reset state ----------------
    tick();
    tick();
    settle();
    chk("rst_vld",  a_out.TVALID, 1'b0);
    chk("rst_dat",  a_out.TDATA, 32'h0);
    chk("rst_rdy",  a_in.TREADY, 1'b0);
    chk("rst_beat", a_beat, 9'd0);
    chk("rst_word", a_word, 9'd0);
    chk("rst_fd",   a_fd, 1'b0);
    ap_rst_n     = 1'b1;
    a_out.TREADY = 1'b1;
    settle();
    chk("rst_release_rdy", a_in.TREADY, 1'b1);

    // ---------------- continuous stream 0x01..0x08 ----------------
    for (int i = 0; i < 8; i++) begin
      a_in.TDATA  = 8'(i + 1);
      a_in.TVALID = 1'b1;
      settle();
      chk("t1_rdy", a_in.TREADY, 1'b1);
      tick();
      chk("t1_vld", a_out.TVALID, (i == 3 || i == 7));
      if (i == 3) chk("t1_word0", a_out.TDATA, 32'h04030201);
      if (i == 7) chk("t1_word1", a_out.TDATA, 32'h08070605);
    end
    a_in.TVALID = 1'b0;
    tick();
    chk("t1_drained", a_out.TVALID, 1'b0);
    chk("t1_beat", a_beat, 9'd8);
    chk("t1_word", a_word, 9'd2);
    chk("t1_fd", a_fd, 1'b0);

    // ---------------- downstream stalled while 0x11..0x18 arrive ----------------
    a_out.TREADY = 1'b0;
    for (int i = 0; i < 7; i++) begin
      a_in.TDATA  = 8'(8'h11 + i);
      a_in.TVALID = 1'b1;
      settle();
      chk("t2_rdy", a_in.TREADY, 1'b1);
      tick();
      if (i >= 3) begin
        chk("t2_hold_vld", a_out.TVALID, 1'b1);
        chk("t2_hold_dat", a_out.TDATA, 32'h14131211);
      end
    end
    a_in.TDATA = 8'h18;
    settle();
    chk("t2_stall_rdy", a_in.TREADY, 1'b0);
    tick();
    chk("t2_stall_dat", a_out.TDATA, 32'h14131211);
    a_out.TREADY = 1'b1;
    settle();
    chk("t2_release_rdy", a_in.TREADY, 1'b1);
    tick();
    chk("t2_nobubble_vld", a_out.TVALID, 1'b1);
    chk("t2_word1", a_out.TDATA, 32'h18171615);
    a_in.TVALID = 1'b0;
    tick();
    chk("t2_drained", a_out.TVALID, 1'b0);
    chk("t2_beat", a_beat, 9'd16);
    chk("t2_word", a_word, 9'd4);

    // ---------------- input gaps delivering 0xA0..0xA3 ----------------
    do_reset();
    a_out.TREADY = 1'b1;
    for (int e = 0; e < 4; e++) begin
      a_in.TDATA  = 8'(8'hA0 + e);
      a_in.TVALID = 1'b1;
      tick();
      chk("t3_vld", a_out.TVALID, (e == 3));
      if (e == 3) chk("t3_word", a_out.TDATA, 32'hA3A2A1A0);
      a_in.TVALID = 1'b0;
      a_in.TDATA  = 8'hEE;
      tick();
      tick();
    end
    chk("t3_beat", a_beat, 9'd4);
    chk("t3_word_cnt", a_word, 9'd1);
    chk("t3_drained", a_out.TVALID, 1'b0);

    // ---------------- reset mid-word ----------------
    a_in.TVALID = 1'b1;
    a_in.TDATA  = 8'h55;
    tick();
    a_in.TDATA  = 8'h66;
    tick();
    ap_rst_n    = 1'b0;
    a_in.TVALID = 1'b0;
    tick();
    settle();
    chk("t4_rdy_in_rst", a_in.TREADY, 1'b0);
    ap_rst_n = 1'b1;
    settle();
    chk("t4_vld", a_out.TVALID, 1'b0);
    chk("t4_beat", a_beat, 9'd0);
    chk("t4_word_cnt", a_word, 9'd0);
    chk("t4_rdy", a_in.TREADY, 1'b1);
    for (int e = 0; e < 4; e++) begin
      a_in.TDATA  = 8'(8'h21 + e);
      a_in.TVALID = 1'b1;
      tick();
    end
    chk("t4_word", a_out.TDATA, 32'h24232221);
    a_in.TVALID = 1'b0;
    tick();

    // Reset with a word pending discards it.
    a_out.TREADY = 1'b0;
    for (int e = 0; e < 4; e++) begin
      a_in.TDATA  = 8'(8'h31 + e);
      a_in.TVALID = 1'b1;
      tick();
    end
    a_in.TVALID = 1'b0;
    chk("t4_pending_vld", a_out.TVALID, 1'b1);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    settle();
    chk("t4_pending_dropped_vld", a_out.TVALID, 1'b0);
    chk("t4_pending_dropped_dat", a_out.TDATA, 32'h0);

    // ---------------- frame wrap with NUM_WORDS=3 (instance b) ----------------
    // Element k is accepted on edge k; word w loads on edge 4w and is taken on 4w+1.
    for (int k = 1; k <= 26; k++) begin
      b_in.TVALID = (k <= 24);
      b_in.TDATA  = 8'(k);
      tick();
      nw = (k >= 5) ? (k - 1) / 4 : 0;
      chk("t5_word_cnt", b_word, 9'(nw % 3));
      chk("t5_fd", b_fd, (k == 13 || k == 25));
      chk("t5_beat", b_beat, 9'((k <= 12) ? k : (k <= 24) ? k - 12 : 0));
      if (k == 4) chk("t5_word0", b_out.TDATA, 32'h04030201);
    end
    b_in.TVALID = 1'b0;

    // ---------------- random valid/ready against scoreboard ----------------
    do_reset();
    void'($urandom(1));
    part       = '0;
    part_n     = 0;
    accepted   = 0;
    words_out  = 0;
    fd_pulses  = 0;
    prev_stall = 1'b0;
    prev_dat   = '0;
    cyc        = 0;
    while (accepted < 10000 && cyc < 60000) begin
      rand_cycle(1'b0);
      cyc++;
    end
    chk("rand_budget", accepted, 10000);
    for (int d = 0; d < 8; d++) rand_cycle(1'b1);
    chk("rand_leftover", exp_q.size(), 0);
    chk("rand_partial", part_n, 0);
    chk("rand_words", words_out, 2500);
    chk("rand_frames", fd_pulses, 9);
    chk("rand_word_cnt", a_word, 9'd196);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
